roic_pixel_capture: RTL
=======================

Name: roic_pixel_capture

Overview:
Downstream consumer of the focal-plane timing controller. Watches its sample/dr/f_sync strobes and latches the ADC word for each pixel. Tags every pixel with row/column coordinates and start-of-frame/end-of-line flags. Delivers pixels through a small first-word-fall-through FIFO on a valid/ready stream toward the frame-buffer writer.

Parameters:
DW, 14, ADC sample width
COLS, 320, pixels per row
ROWS, 240, rows per frame
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock; all registers update on rising edge (timing controller drives on falling edge, so inputs are stable here)
rst  in  1  synchronous reset, active-low
sample  in  1  sample strobe from timing controller
dr  in  1  data-ready qualifier from timing controller
f_sync  in  1  frame sync from timing controller
adc_data  in  DW  ADC conversion result
clr_status  in  1  clears sticky status bits
pix_ready  in  1  downstream ready
pix_valid  out  1  FIFO non-empty
pix_data  out  DW  pixel value
pix_row  out  8  row index 0..ROWS-1
pix_col  out  9  column index 0..COLS-1
pix_sof  out  1  first pixel of frame (row 0, col 0)
pix_eol  out  1  last pixel of row (col COLS-1)
frame_done  out  1  one-cycle pulse after last pixel of frame captured
ovf  out  1  sticky: pixel dropped because FIFO full
frame_err  out  1  sticky: f_sync arrived before frame complete

Behaviour:
- Reset (rst==0 at rising edge): state IDLE; row/col counters 0; FIFO empty; sample_d, f_sync_d = 0; all outputs 0.
- States:
  - IDLE: wait for f_sync rise.
  - ACTIVE: capturing.
  - DONE: frame complete, wait for next f_sync rise.
- f_sync rise = f_sync && !f_sync_d.
  - In any state: row=col=0, state -> ACTIVE.
  - If the state was ACTIVE and at least one pixel had been captured: frame_err <= 1.
  - FIFO is not flushed.
- Capture event = sample_d && !sample && dr && state==ACTIVE.
  - adc_data is taken in the same cycle as the event.
  - Capture events in IDLE or DONE are ignored.
- Simultaneous f_sync rise and capture event: f_sync wins; the capture is discarded.
- Entry pushed per capture: {adc_data, row, col, sof=(row==0&&col==0), eol=(col==COLS-1)}.
- Counter advance on each capture, including dropped pixels:
  - col+1.
  - At col==COLS-1: col=0, row+1.
  - At row==ROWS-1 and col==COLS-1: state -> DONE; frame_done=1 in the next cycle only.
- FIFO:
  - Push when not full.
  - If full and no pop in the same cycle: entry dropped, ovf <= 1.
  - If full and pop in the same cycle: push accepted, no overflow.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- Output stream:
  - pix_valid = !empty; pop when pix_valid && pix_ready.
  - pix_* are driven from the head entry and stay stable while pix_valid && !pix_ready.
  - Latency: capture at cycle N with FIFO empty -> pix_valid=1 at N+1.
- Status: clr_status clears ovf and frame_err; a set event in the same cycle wins over clear.
- Reset asserted mid-frame: everything returns to reset values next edge; in-flight pixels are lost.

Test Plan:
- Reset release, f_sync pulse, 3 sample falling edges with dr=1, adc_data 0x100/0x101/0x102, pix_ready=1 -> three beats with (row,col) (0,0),(0,1),(0,2); sof only on first; pix_valid rises 1 cycle after each capture.
- Full frame of 76800 captures, continuous ready -> eol on every col 319; last beat (239,319); frame_done single pulse; further sample edges produce no beats until next f_sync.
- pix_ready=0 and 6 captures with FIFO_DEPTH=4 -> 4 entries held (data stable), ovf=1 after 5th; ready=1 -> 4 beats, then the next capture is tagged col 6; clr_status -> ovf=0.
- f_sync rise after 500 captures -> frame_err=1; next capture tagged (0,0) with sof=1; f_sync rise in the same cycle as a sample falling edge -> that capture is discarded.
- sample falling edges with dr=0, or in IDLE before any f_sync -> no pix_valid; counters unchanged.
- rst=0 for one cycle mid-frame with FIFO holding 3 entries -> pix_valid=0, all status 0, state IDLE next cycle.

Source files
------------

// File: rtl/roic_pixel_capture.sv
// Pixel capture stage behind the focal-plane timing controller: latches ADC words on
// qualified sample falling edges, tags them with frame coordinates and streams them out through a FWFT FIFO.
module roic_pixel_capture #(
    parameter int DW         = 14,
    parameter int COLS       = 320,
    parameter int ROWS       = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample,
    input  logic          dr,
    input  logic          f_sync,
    input  logic [DW-1:0] adc_data,
    input  logic          clr_status,
    input  logic          pix_ready,
    output logic          pix_valid,
    output logic [DW-1:0] pix_data,
    output logic [7:0]    pix_row,
    output logic [8:0]    pix_col,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          frame_done,
    output logic          ovf,
    output logic          frame_err
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam int         EW       = DW + 19;
    localparam logic [8:0] COL_LAST = 9'(COLS - 1);
    localparam logic [7:0] ROW_LAST = 8'(ROWS - 1);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e          state_q;
    logic            sample_q;
    logic            f_sync_q;
    logic [7:0]      row_q;
    logic [8:0]      col_q;
    logic            got_pix_q;
    logic            frame_done_q;
    logic            ovf_q;
    logic            frame_err_q;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;

    logic            fsync_rise_s;
    logic            capture_s;
    logic            full_s;
    logic            empty_s;
    logic            pop_s;
    logic            push_ok_s;
    logic            drop_s;
    logic            col_last_s;
    logic            row_last_s;
    logic            ferr_set_s;
    logic [EW-1:0]   entry_s;
    logic [EW-1:0]   head_s;

    // f_sync outranks a coincident capture: the capture is discarded, not deferred.
    assign fsync_rise_s = f_sync & ~f_sync_q;
    assign capture_s    = sample_q & ~sample & dr & (state_q == ST_ACTIVE) & ~fsync_rise_s;
    assign col_last_s   = (col_q == COL_LAST);
    assign row_last_s   = (row_q == ROW_LAST);
    assign ferr_set_s   = fsync_rise_s & (state_q == ST_ACTIVE) & got_pix_q;

    assign full_s       = (count_q == FULL_CNT);
    assign empty_s      = (count_q == {(AW+1){1'b0}});
    assign pop_s        = ~empty_s & pix_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok_s    = capture_s & (~full_s | pop_s);
    assign drop_s       = capture_s & full_s & ~pop_s;

    assign entry_s = {adc_data, row_q, col_q,
                      (row_q == 8'd0) & (col_q == 9'd0), col_last_s};
    assign head_s  = mem_q[rd_ptr_q];

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Frame FSM, edge-detect history and coordinate counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sample_q     <= 1'b0;
            f_sync_q     <= 1'b0;
            row_q        <= 8'd0;
            col_q        <= 9'd0;
            got_pix_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sample_q     <= sample;
            f_sync_q     <= f_sync;
            frame_done_q <= 1'b0;
            if (fsync_rise_s) begin
                state_q   <= ST_ACTIVE;
                row_q     <= 8'd0;
                col_q     <= 9'd0;
                got_pix_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ACTIVE: begin
                        if (capture_s) begin
                            got_pix_q <= 1'b1;
                            if (col_last_s) begin
                                col_q <= 9'd0;
                                if (row_last_s) begin
                                    row_q        <= 8'd0;
                                    state_q      <= ST_DONE;
                                    frame_done_q <= 1'b1;
                                end else begin
                                    row_q <= row_q + 8'd1;
                                end
                            end else begin
                                col_q <= col_q + 9'd1;
                            end
                        end
                    end
                    ST_IDLE, ST_DONE: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky status; a set event in the same cycle beats clr_status.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ovf_q       <= drop_s | (ovf_q & ~clr_status);
            frame_err_q <= ferr_set_s | (frame_err_q & ~clr_status);
        end
    end

    // Output FIFO storage and pointers; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= entry_s;
                wr_ptr_q        <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            count_q <= count_d;
        end
    end

    // Head fields are forced to zero while empty so stale entries never leak out.
    assign pix_valid  = ~empty_s;
    assign pix_data   = pix_valid ? head_s[EW-1:19] : {DW{1'b0}};
    assign pix_row    = pix_valid ? head_s[18:11]   : 8'd0;
    assign pix_col    = pix_valid ? head_s[10:2]    : 9'd0;
    assign pix_sof    = pix_valid & head_s[1];
    assign pix_eol    = pix_valid & head_s[0];
    assign frame_done = frame_done_q;
    assign ovf        = ovf_q;
    assign frame_err  = frame_err_q;

endmodule
